// File: rtl/probe_uplink_sink.sv
// probe_uplink_sink
// -----------------------------------------------------------------------------
// Root-end receiver of the 32-bit probe uplink tree. Owns the ACK side of the
// DATAUP/DATAVALID/DELAY/ACK handshake, buffers captured words in a small
// first-word-fallthrough FIFO and presents them on a valid/ready stream.
// Also reports uplink idle and keeps wrapping captured/dropped word counters.
//
// Ports:
//   UCLK        clock, all state updates on the rising edge
//   URST_N      asynchronous active-low reset
//   DATAUP      probe word offered by the uplink
//   DATAVALID   DATAUP holds a word offered for transfer
//   DELAY       some node below still holds or is sending probe data
//   ACK         sink accepts the offered word this cycle
//   EN          1 = capture into FIFO, 0 = accept and discard
//   OUT_DATA    head-of-FIFO word (0 while empty)
//   OUT_VALID   FIFO non-empty
//   OUT_READY   host consumes the head word
//   IDLE        uplink quiescent and FIFO empty
//   WORD_COUNT  words captured into the FIFO, modulo 2^16
//   DROP_COUNT  words discarded while EN = 0, modulo 2^16
// -----------------------------------------------------------------------------
module probe_uplink_sink #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        UCLK,
  input  logic        URST_N,
  input  logic [31:0] DATAUP,
  input  logic        DATAVALID,
  input  logic        DELAY,
  output logic        ACK,
  input  logic        EN,
  output logic [31:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        IDLE,
  output logic [15:0] WORD_COUNT,
  output logic [15:0] DROP_COUNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // count needs one extra bit so that "full" (count == DEPTH) is representable.
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [15:0]           word_count_reg, word_count_next;
  logic [15:0]           drop_count_reg, drop_count_next;
  logic [31:0]           mem [DEPTH];

  logic full;
  logic push;
  logic drop;
  logic pop;

  // Depth is a power of two, so the MSB of count alone marks "full".
  assign full = count_reg[DEPTH_LOG2];

  // ACK depends only on registered state, EN and reset: the upstream mux
  // derives its own ACK from ours, so no path from DATAVALID/OUT_READY.
  assign ACK = URST_N && (!EN || !full);

  assign push = DATAVALID && ACK && EN;
  assign drop = DATAVALID && ACK && !EN;
  assign pop  = OUT_VALID && OUT_READY;

  assign OUT_VALID  = (count_reg != '0);
  // Storage is not reset; masking keeps OUT_DATA at 0 whenever empty.
  assign OUT_DATA   = OUT_VALID ? mem[rd_ptr_reg] : 32'h0;
  assign IDLE       = !DELAY && !DATAVALID && (count_reg == '0);
  assign WORD_COUNT = word_count_reg;
  assign DROP_COUNT = drop_count_reg;

  always_comb begin
    count_next      = count_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    word_count_next = word_count_reg;
    drop_count_next = drop_count_reg;

    if (push) begin
      wr_ptr_next     = wr_ptr_reg + 1'b1;
      word_count_next = word_count_reg + 16'd1;
    end
    if (drop) begin
      drop_count_next = drop_count_reg + 16'd1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge UCLK or negedge URST_N) begin
    if (!URST_N) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      word_count_reg <= '0;
      drop_count_reg <= '0;
    end else begin
      count_reg      <= count_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      word_count_reg <= word_count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // Data storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge UCLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= DATAUP;
    end
  end

endmodule

// File: doc/probe_uplink_sink.md
Name: probe_uplink_sink

Overview:
Root-end receiver for the 32-bit probe uplink tree. It terminates the uplink produced by the top probe mux and owns the ACK side of the DATAUP/DATAVALID/DELAY/ACK handshake. Accepted probe words go into a small first-word-fallthrough FIFO and are presented to the host-side capture logic on a valid/ready stream. The block also provides an idle indication and wrapping word and drop counters for software.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 words); legal range 1..6.

Ports:
- UCLK  input  1  clock; all state updates on rising edge.
- URST_N  input  1  asynchronous active-low reset.
- DATAUP  input  32  probe word from the uplink.
- DATAVALID  input  1  DATAUP holds a word offered for transfer.
- DELAY  input  1  some node below still holds or is sending probe data.
- ACK  output  1  sink accepts the offered word this cycle.
- EN  input  1  1 = capture into FIFO; 0 = drain mode (accept and discard).
- OUT_DATA  output  32  head-of-FIFO word.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_READY  input  1  host consumes the head word.
- IDLE  output  1  uplink quiescent and FIFO empty.
- WORD_COUNT  output  16  number of words captured into the FIFO, modulo 2^16.
- DROP_COUNT  output  16  number of words discarded in drain mode, modulo 2^16.

Behaviour:
- Single clock domain, UCLK. Reset is asynchronous and active-low on URST_N. All state clears immediately on URST_N low.
- Reset state:
  - FIFO count, read pointer and write pointer = 0.
  - WORD_COUNT = 0, DROP_COUNT = 0, OUT_VALID = 0.
  - OUT_DATA = 0 (storage is cleared or masked while empty).
  - ACK = 0 while URST_N is low.
- ACK (combinational from registered count and EN only; no path from OUT_READY or DATAVALID):
  - ACK = URST_N && (!EN || count < 2^DEPTH_LOG2).
- Transfer: a word moves on any rising edge where DATAVALID && ACK. The upstream mux may change DATAUP or DATAVALID in the same edge, because its ACK is combinationally derived from ours.
- EN = 1 at the transfer edge:
  - DATAUP is written at the write pointer; write pointer increments, wrapping at the depth.
  - count increments.
  - WORD_COUNT increments, wrapping 0xFFFF -> 0x0000.
- EN = 0 at the transfer edge:
  - Word is discarded; FIFO is untouched.
  - DROP_COUNT increments, wrapping.
  - EN is sampled on the same edge as the transfer.
- Output side:
  - OUT_VALID = (count != 0).
  - OUT_DATA = entry at the read pointer.
  - Pop on any edge where OUT_VALID && OUT_READY: read pointer increments (wraps), count decrements.
  - Latency from an accepted word into an empty FIFO to OUT_VALID = 1 cycle.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any count from 1 to depth-1, and at full only when EN = 0 (no push occurs then).
- Full with EN = 1: ACK = 0 and the upstream holds its word. ACK returns on the cycle after a pop reduces count.
- Empty FIFO with OUT_READY high: no pop, no underflow, pointers unchanged.
- Clearing EN does not flush the FIFO. Stored words still drain to the host.
- IDLE = !DELAY && !DATAVALID && count == 0 (combinational).
- Reset asserted mid-transfer: buffered words are lost, counters clear, and ACK drops asynchronously. After release, the upstream word still offered is accepted normally.
- DATAUP is ignored whenever DATAVALID = 0, including when it carries X or initial-pattern values.

Test Plan:
- Reset, then EN = 1 and OUT_READY = 0; offer 0x00000001..0x00000008 back-to-back:
  - ACK stays high for all 8 words, then falls.
  - OUT_VALID is high 1 cycle after the first accept.
  - WORD_COUNT = 8.
  - A 9th word 0xDEADBEEF is held with ACK = 0.
- From that full state, pulse OUT_READY for 1 cycle:
  - OUT_DATA changes 0x1 -> 0x2.
  - ACK rises the next cycle and 0xDEADBEEF is accepted.
  - WORD_COUNT = 9.
  - Draining then yields 0x2..0x8 followed by 0xDEADBEEF, in order.
- EN = 0 with 3 words already buffered; offer 5 words:
  - ACK is high every cycle and all 5 words are discarded.
  - DROP_COUNT = 5 and WORD_COUNT is unchanged.
  - The 3 buffered words still drain to the host.
- Continuous DATAVALID with OUT_READY = 1 for 20 cycles at EN = 1:
  - Throughput is 1 word per cycle.
  - count settles at 1 and ACK never drops.
  - Output order matches input order.
- Preload WORD_COUNT to 0xFFFF by streaming 65535 words, then accept 1 more:
  - WORD_COUNT = 0x0000.
  - IDLE = 1 only once DELAY = 0, DATAVALID = 0 and the FIFO has drained.
- Assert URST_N low mid-stream with 4 words buffered and DATAVALID high:
  - OUT_VALID, ACK and both counters go to 0 immediately, without waiting for a clock edge.
  - After release, the pending word is accepted on the first edge.
